fetch_ctrl: RTL and testbench

//  Sequences instruction fetch: owns the program-counter register, issues requests to instruction memory.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_watchdog.sv | 19 +
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch controller.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: saturating wait counter that flags when a request has waited TIMEOUT cycles.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count && cnt != W'(TIMEOUT - 1)) cnt <= cnt + W'(1);
    end
    assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer owning the PC, the imem request and the decode holding register.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              TIMEOUT   = 16
) (
    input  logic            fc_clk,
    input  logic            fc_rst_n,
    input  logic            fc_enable,
    input  logic            fc_jump_enb,
    input  logic [XLEN-1:0] fc_jump_base,
    input  logic [XLEN-1:0] fc_jump_offset,
    output logic            fc_imem_req,
    output logic [XLEN-1:0] fc_imem_addr,
    input  logic            fc_imem_ack,
    input  logic [XLEN-1:0] fc_imem_rdata,
    output logic            fc_instr_valid,
    output logic [XLEN-1:0] fc_instr,
    output logic [XLEN-1:0] fc_instr_pc,
    input  logic            fc_instr_ready,
    output logic            fc_fault,
    output logic [1:0]      fc_fault_code
);
    state_t          state;
    logic [XLEN-1:0] pc, pend, target;
    logic            drop, expired, accept, jump_bad;
    assign target       = fc_jump_base + fc_jump_offset;
    assign accept       = fc_instr_valid & fc_instr_ready;
    assign jump_bad     = fc_jump_enb & (|target[1:0]) & (state != FAULT);
    assign fc_imem_addr = pc;
    fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (fc_clk),
        .rst_n  (fc_rst_n),
        .clear  ((state != REQ) | fc_imem_ack),
        .count  (state == REQ),
        .expired(expired)
    );
    always_ff @(posedge fc_clk or negedge fc_rst_n) begin
        if (!fc_rst_n) begin
            state          <= IDLE;
            pc             <= RESET_VEC;
            pend           <= '0;
            drop           <= 1'b0;
            fc_imem_req    <= 1'b0;
            fc_instr_valid <= 1'b0;
            fc_instr       <= '0;
            fc_instr_pc    <= '0;
            fc_fault       <= 1'b0;
            fc_fault_code  <= '0;
        end else if (jump_bad) begin
            state          <= FAULT;
            drop           <= 1'b0;
            fc_imem_req    <= 1'b0;
            fc_instr_valid <= 1'b0;
            fc_fault       <= 1'b1;
            fc_fault_code  <= FAULT_MISALIGN;
        end else begin
            case (state)
                IDLE: begin
                    if (fc_jump_enb) pc <= target;
                    if (fc_enable) begin
                        state       <= REQ;
                        fc_imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    // A response to a superseded address is discarded and the new target issued back-to-back
                    if (fc_imem_ack && (drop || fc_jump_enb)) begin
                        pc   <= fc_jump_enb ? target : pend;
                        drop <= 1'b0;
                    end else if (fc_imem_ack) begin
                        fc_instr       <= fc_imem_rdata;
                        fc_instr_pc    <= pc;
                        fc_instr_valid <= 1'b1;
                        fc_imem_req    <= 1'b0;
                        state          <= HOLD;
                    end else begin
                        if (fc_jump_enb) begin
                            drop <= 1'b1;
                            pend <= target;
                        end
                        if (expired) begin
                            state         <= FAULT;
                            fc_imem_req   <= 1'b0;
                            fc_fault      <= 1'b1;
                            fc_fault_code <= FAULT_TIMEOUT;
                        end
                    end
                end
                HOLD: begin
                    if (fc_jump_enb || accept) begin
                        pc             <= fc_jump_enb ? target : pc + XLEN'(INSTR_BYTES);
                        fc_instr_valid <= 1'b0;
                        fc_imem_req    <= fc_enable;
                        state          <= fc_enable ? REQ : IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, jump = 1'b0, ack = 1'b0, ready = 1'b0;
    logic [31:0] base = '0, offset = '0, rdata = '0;
    logic        req, valid, fault;
    logic [31:0] addr, instr, instr_pc;
    logic [1:0]  code;
    int compared = 0, mismatched = 0;

    fetch_ctrl #(.XLEN(32), .RESET_VEC(32'h0), .TIMEOUT(16)) dut (
        .fc_clk(clk), .fc_rst_n(rst_n), .fc_enable(enable), .fc_jump_enb(jump),
        .fc_jump_base(base), .fc_jump_offset(offset), .fc_imem_req(req), .fc_imem_addr(addr),
        .fc_imem_ack(ack), .fc_imem_rdata(rdata), .fc_instr_valid(valid), .fc_instr(instr),
        .fc_instr_pc(instr_pc), .fc_instr_ready(ready), .fc_fault(fault), .fc_fault_code(code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Request at a, ack two cycles later with d, accepted immediately by decode.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        chk("req_up", {31'b0, req}, 32'd1);
        chk("req_addr", addr, a);
        tick();
        tick();
        ack = 1'b1;
        rdata = d;
        tick();
        ack = 1'b0;
        chk("valid_up", {31'b0, valid}, 32'd1);
        chk("instr", instr, d);
        chk("instr_pc", instr_pc, a);
        chk("req_down", {31'b0, req}, 32'd0);
        tick();
        chk("valid_bubble", {31'b0, valid}, 32'd0);
    endtask

    initial begin
        ack = 1'b1;
        rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_code", {30'b0, code}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        // basic stream
        ack = 1'b0;
        rst_n = 1'b1;
        enable = 1'b1;
        ready = 1'b1;
        tick();
        do_fetch(32'h0, 32'hA0);
        do_fetch(32'h4, 32'hA4);
        // decode stall
        chk("stall_addr", addr, 32'h8);
        ready = 1'b0;
        tick();
        tick();
        ack = 1'b1;
        rdata = 32'hB8;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_instr", instr, 32'hB8);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_noreq", {31'b0, req}, 32'd0);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("stall_release_valid", {31'b0, valid}, 32'd0);
        chk("stall_next_addr", addr, 32'hC);
        // jump while request outstanding
        tick();
        jump = 1'b1;
        base = 32'h100;
        offset = 32'hFFFF_FFE0;
        tick();
        jump = 1'b0;
        chk("drop_req_held", {31'b0, req}, 32'd1);
        chk("drop_addr_held", addr, 32'hC);
        tick();
        ack = 1'b1;
        rdata = 32'hDEAD;
        tick();
        ack = 1'b0;
        chk("drop_valid", {31'b0, valid}, 32'd0);
        chk("drop_req_again", {31'b0, req}, 32'd1);
        chk("drop_new_addr", addr, 32'hE0);
        do_fetch(32'hE0, 32'h1234);
        // jump in HOLD with same-cycle accept
        tick();
        tick();
        ack = 1'b1;
        rdata = 32'h55;
        tick();
        ack = 1'b0;
        chk("hold_valid", {31'b0, valid}, 32'd1);
        chk("hold_pc", instr_pc, 32'hE4);
        jump = 1'b1;
        base = 32'h40;
        offset = 32'h8;
        tick();
        jump = 1'b0;
        chk("hjump_valid", {31'b0, valid}, 32'd0);
        chk("hjump_addr", addr, 32'h48);
        // enable low finishes the fetch then idles; jump in IDLE moves pc
        enable = 1'b0;
        do_fetch(32'h48, 32'h77);
        chk("idle_req", {31'b0, req}, 32'd0);
        chk("idle_addr", addr, 32'h4C);
        jump = 1'b1;
        base = 32'h200;
        offset = 32'h0;
        tick();
        jump = 1'b0;
        chk("idle_jump_req", {31'b0, req}, 32'd0);
        chk("idle_jump_addr", addr, 32'h200);
        enable = 1'b1;
        tick();
        // misaligned jump
        chk("mis_pre_addr", addr, 32'h200);
        jump = 1'b1;
        base = 32'h100;
        offset = 32'h2;
        tick();
        jump = 1'b0;
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_code", {30'b0, code}, 32'd1);
        chk("mis_req", {31'b0, req}, 32'd0);
        ack = 1'b1;
        jump = 1'b1;
        base = 32'h300;
        offset = 32'h0;
        tick();
        ack = 1'b0;
        jump = 1'b0;
        tick();
        chk("mis_sticky", {31'b0, fault}, 32'd1);
        chk("mis_code_sticky", {30'b0, code}, 32'd1);
        chk("mis_valid", {31'b0, valid}, 32'd0);
        chk("mis_req_sticky", {31'b0, req}, 32'd0);
        chk("mis_addr_frozen", addr, 32'h200);
        // reset clears fault, then timeout
        rst_n = 1'b0;
        #1;
        chk("clr_fault", {31'b0, fault}, 32'd0);
        chk("clr_code", {30'b0, code}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("to_req0", {31'b0, req}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_req", {31'b0, req}, 32'd1);
            chk("to_wait_fault", {31'b0, fault}, 32'd0);
        end
        tick();
        chk("to_fault", {31'b0, fault}, 32'd1);
        chk("to_code", {30'b0, code}, 32'd2);
        chk("to_req", {31'b0, req}, 32'd0);
        // async reset mid-request
        rst_n = 1'b0;
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        jump = 1'b1;
        base = 32'h300;
        offset = 32'h0;
        tick();
        jump = 1'b0;
        enable = 1'b1;
        tick();
        chk("ar_req", {31'b0, req}, 32'd1);
        chk("ar_addr", addr, 32'h300);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_low", {31'b0, req}, 32'd0);
        chk("ar_addr_vec", addr, 32'h0);
        chk("ar_fault", {31'b0, fault}, 32'd0);
        chk("ar_valid", {31'b0, valid}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
